// File: rtl/des_round_engine_if.sv
// des_round_engine_if: block, subkey, S-box and result handshake bundle.
// master = environment side, slave = round engine side.
interface des_round_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] block_in;
  logic [47:0] subkey_in;
  logic [3:0]  round_idx;
  logic [47:0] sbox_in;
  logic [31:0] sbox_out;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] block_out;
  logic        busy;

  modport master (
    output in_valid, block_in, subkey_in,
    output sbox_out, out_ready,
    input  in_ready, round_idx, sbox_in,
    input  out_valid, block_out, busy
  );

  modport slave (
    input  in_valid, block_in, subkey_in,
    input  sbox_out, out_ready,
    output in_ready, round_idx, sbox_in,
    output out_valid, block_out, busy
  );
endinterface

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES Feistel datapath, one round per clock.
// Define DES_IP_FP_EN to apply IP on load and FP (IP^-1) on the result.
module des_round_engine #(
  parameter int NUM_ROUNDS = 16
) (
  input logic               clk,
  input logic               rst_n,
  des_round_engine_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] out_q, out_d;
  logic [31:0] f;
  logic [63:0] blk_ld;
  logic [63:0] blk_fin;

  function automatic logic [47:0] expand(input logic [31:0] r);
    return {r[0], r[31:27], r[28:23], r[24:19],
            r[20:15], r[16:11], r[12:7], r[8:3],
            r[4:0], r[31]};
  endfunction

  function automatic logic [31:0] pperm(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11],
            s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],
            s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18],
            s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26],
            s[10], s[21], s[28], s[7]};
  endfunction

`ifdef DES_IP_FP_EN
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9,  1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9,  49, 17, 57, 25};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++)
      o[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++)
      o[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return o;
  endfunction

  assign blk_ld  = ip(bus.block_in);
  assign blk_fin = fp({l_q ^ f, r_q});
`else
  assign blk_ld  = bus.block_in;
  assign blk_fin = {l_q ^ f, r_q};
`endif

  assign f         = pperm(bus.sbox_out);
  assign bus.sbox_in   = expand(r_q) ^ bus.subkey_in;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.block_out = out_q;
  assign bus.round_idx = idx_q;

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    idx_d   = idx_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          l_d     = blk_ld[63:32];
          r_d     = blk_ld[31:0];
          idx_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        l_d = r_q;
        r_d = l_q ^ f;
        // result is captured with the swap undone on the last round
        if (idx_q == LAST) begin
          out_d   = blk_fin;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: directed DES vectors, backpressure, back-to-back, reset.
// Bench supplies key schedule, S-boxes and, without DES_IP_FP_EN, IP/FP.
module tb_des_round_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_round_engine_if bus ();
  des_round_engine_if bus1 ();

  des_round_engine #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  des_round_engine #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFT_T [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

`ifndef DES_IP_FP_EN
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9,  49, 17, 57, 25};

  function automatic logic [63:0] perm64(input logic [63:0] x,
                                         input int t [64]);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++)
      o[6'(63 - i)] = x[6'(64 - t[i])];
    return o;
  endfunction
`endif

  function automatic logic [63:0] pre(input logic [63:0] b);
`ifdef DES_IP_FP_EN
    return b;
`else
    return perm64(b, IP_T);
`endif
  endfunction

  function automatic logic [63:0] post(input logic [63:0] b);
`ifdef DES_IP_FP_EN
    return b;
`else
    return perm64(b, FP_T);
`endif
  endfunction

  function automatic logic [31:0] sbox_f(input logic [47:0] x);
    logic [31:0] o;
    logic [5:0]  b;
    int          row, col;
    o = '0;
    for (int j = 0; j < 8; j++) begin
      b   = 6'(x >> (42 - 6 * j));
      row = int'({b[5], b[0]});
      col = int'(b[4:1]);
      o   = {o[27:0], 4'(SB[j * 64 + row * 16 + col])};
    end
    return o;
  endfunction

  logic [47:0] ks [16];
  logic        dec;

  task automatic set_key(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    cd = '0;
    for (int i = 0; i < 56; i++)
      cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFT_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++)
        ks[r][6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    end
  endtask

  always_comb begin
    bus.subkey_in = dec ? ks[4'd15 - bus.round_idx]
                        : ks[bus.round_idx];
    bus.sbox_out  = sbox_f(bus.sbox_in);
  end

  assign bus1.subkey_in = '0;
  assign bus1.sbox_out  = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] blk, input logic d);
    int n;
    n = 0;
    dec = d;
    bus.block_in = pre(blk);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("send_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int bad);
    lat = 0;
    bad = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.round_idx !== 4'(lat)) bad++;
      tick();
      lat++;
    end
  endtask

  logic [63:0] b2b_in  [4];
  logic [63:0] b2b_exp [4];
  logic        b2b_dec [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bad, stable, na, no, cyc, last_acc, gap_bad, idx_bad;
    logic        acc;
    logic [63:0] snap;

    rst_n         = 1'b0;
    dec           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.block_in  = '0;
    bus.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.block_in  = '0;
    bus1.out_ready = 1'b1;
    set_key(KEY1);

    repeat (3) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_block_out", bus.block_out, 64'd0);
    chk("rst_round_idx", 64'(bus.round_idx), 64'd0);

    send(PT1, 1'b0);
    chk("accept_busy", 64'({bus.busy, bus.in_ready}), 64'd2);
    wait_out(lat, bad);
    chk("enc_latency", 64'(lat), 64'd16);
    chk("enc_round_seq", 64'(bad), 64'd0);
    chk("enc_fips", post(bus.block_out), CT1);
    chk("done_idx_hold", 64'(bus.round_idx), 64'd15);

    snap = bus.block_out;
    dec = 1'b1;
    bus.block_in = pre(CT1);
    bus.in_valid = 1'b1;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.block_out !== snap || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1 || bus.busy !== 1'b1)
        stable = 0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", 64'({bus.in_ready, bus.out_valid}), 64'd2);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_second_accept", 64'({bus.busy, bus.round_idx}), 64'h10);
    wait_out(lat, bad);
    chk("dec_latency", 64'(lat), 64'd16);
    chk("dec_fips", post(bus.block_out), PT1);
    tick();

    set_key(64'h0E329232EA6D0D73);
    send(64'h8787878787878787, 1'b0);
    wait_out(lat, bad);
    chk("enc_key2", post(bus.block_out), 64'h0);
    tick();

    set_key(KEY1);
    b2b_in  = '{PT1, CT1, PT1, CT1};
    b2b_exp = '{CT1, PT1, CT1, PT1};
    b2b_dec = '{1'b0, 1'b1, 1'b0, 1'b1};
    na = 0; no = 0; cyc = 0; last_acc = 0;
    gap_bad = 0; idx_bad = 0;
    bus.block_in = pre(b2b_in[0]);
    bus.in_valid = 1'b1;
    while (no < 4 && cyc < 200) begin
      acc = bus.in_ready && bus.in_valid;
      tick();
      cyc++;
      if (acc) begin
        if (na > 0 && cyc - last_acc != 18) gap_bad++;
        last_acc = cyc;
        dec = b2b_dec[na];
        na++;
        if (na < 4) bus.block_in = pre(b2b_in[na]);
        else bus.in_valid = 1'b0;
      end
      if (bus.busy && !bus.out_valid &&
          bus.round_idx !== 4'(cyc - last_acc))
        idx_bad++;
      if (bus.out_valid) begin
        chk($sformatf("b2b_out%0d", no), post(bus.block_out),
            b2b_exp[no]);
        no++;
      end
    end
    chk("b2b_count", 64'(no), 64'd4);
    chk("b2b_gap18", 64'(gap_bad), 64'd0);
    chk("b2b_round_idx", 64'(idx_bad), 64'd0);
    tick();

    bus1.block_in = 64'hAAAAAAAA55555555;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("r1_latency", 64'(lat), 64'd1);
    chk("r1_block_out", bus1.block_out, 64'hAAAAAAAA55555555);
    tick();

    bus.out_ready = 1'b0;
    send(PT1, 1'b0);
    wait_out(lat, bad);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_done_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_done_block", bus.block_out, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    send(PT1, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_round_state",
        64'({bus.out_valid, bus.busy, bus.in_ready}), 64'd1);
    chk("rst_round_idx0", 64'(bus.round_idx), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    send(PT1, 1'b0);
    wait_out(lat, bad);
    chk("post_rst_enc", post(bus.block_out), CT1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
